// File: rtl/vm_event_timer_if.sv
// vm_event_timer_if: control/status bundle of the line-clock event timer.
// Carries freq_sel, mode, evnt_ack, timer_button in; tick, evnt, timer_status, overrun out.
interface vm_event_timer_if;
    logic freq_sel;
    logic mode;
    logic evnt_ack;
    logic timer_button;
    logic tick;
    logic evnt;
    logic timer_status;
    logic overrun;

    modport master (
        output freq_sel,
        output mode,
        output evnt_ack,
        output timer_button,
        input  tick,
        input  evnt,
        input  timer_status,
        input  overrun
    );

    modport slave (
        input  freq_sel,
        input  mode,
        input  evnt_ack,
        input  timer_button,
        output tick,
        output evnt,
        output timer_status,
        output overrun
    );
endinterface

// File: rtl/vm_event_timer.sv
// vm_event_timer: periodic line-clock interrupt request with debounced enable button.
// Ports: clk_p, rst_n (async, active-low), bus (slave side of vm_event_timer_if).
module vm_event_timer #(
    parameter int unsigned DIV_A      = 2000000,
    parameter int unsigned DIV_B      = 1666667,
    parameter int unsigned CNT_W      = 21,
    parameter int unsigned PULSE_W    = 1,
    parameter int unsigned DEB_DEPTH  = 2,
    parameter bit          TIMER_INIT = 1'b1
) (
    input  logic           clk_p,
    input  logic           rst_n,
    vm_event_timer_if.slave bus
);

    localparam logic [CNT_W-1:0] LIM_A = CNT_W'(DIV_A - 1);
    localparam logic [CNT_W-1:0] LIM_B = CNT_W'(DIV_B - 1);
    localparam int unsigned      PW_W  = $clog2(PULSE_W + 1);
    localparam logic [PW_W-1:0]  PW_LD = PW_W'(PULSE_W - 1);

    // ---------------- divider ----------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] lim_nxt;
    logic             sel_q;
    logic             sel_nxt;
    logic             wrap;
    logic             tick_q;

    assign lim     = sel_q ? LIM_B : LIM_A;
    assign wrap    = (cnt_q == lim);
    assign cnt_nxt = wrap ? '0 : cnt_q + 1'b1;
    // The divisor is only re-selected at the wrap, so no period is cut short.
    assign sel_nxt = wrap ? bus.freq_sel : sel_q;
    assign lim_nxt = sel_nxt ? LIM_B : LIM_A;

    // tick is registered: it is raised for the cycle in which the counter
    // sits on its terminal value, by looking one count ahead.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sel_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            sel_q  <= sel_nxt;
            tick_q <= (cnt_nxt == lim_nxt);
        end
    end

    // ---------------- button ----------------
    logic                 sync1_q;
    logic                 sync2_q;
    logic [DEB_DEPTH-1:0] sh_q;
    logic [DEB_DEPTH:0]   sh_cat;
    logic [DEB_DEPTH-1:0] sh_nxt;
    logic                 armed_q;
    logic                 status_q;

    assign sh_cat = {sh_q, sync2_q};
    assign sh_nxt = sh_cat[DEB_DEPTH-1:0];

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.timer_button;
            sync2_q <= sync1_q;
        end
    end

    // Debounce samples once per tick; a stable-high run toggles the enable
    // once, and it must see a stable-low run before it can toggle again.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            sh_q     <= '0;
            armed_q  <= 1'b1;
            status_q <= TIMER_INIT;
        end else if (tick_q) begin
            sh_q <= sh_nxt;
            if ((&sh_nxt) && armed_q) begin
                status_q <= ~status_q;
                armed_q  <= 1'b0;
            end else if (~|sh_nxt) begin
                armed_q <= 1'b1;
            end
        end
    end

    // ---------------- request ----------------
    logic [PW_W-1:0] pcnt_q;
    logic [PW_W-1:0] pcnt_nxt;
    logic            evnt_q;
    logic            evnt_nxt;
    logic            ovr_q;
    logic            ovr_nxt;

    always_comb begin
        pcnt_nxt = pcnt_q;
        evnt_nxt = evnt_q;
        ovr_nxt  = ovr_q;
        if (!status_q) begin
            // Disabled: drop any request; overrun stays until acknowledged.
            pcnt_nxt = '0;
            evnt_nxt = 1'b0;
            if (bus.mode && bus.evnt_ack) begin
                ovr_nxt = 1'b0;
            end
        end else if (!bus.mode) begin
            if (tick_q) begin
                evnt_nxt = 1'b1;
                pcnt_nxt = PW_LD;
            end else if (pcnt_q != '0) begin
                pcnt_nxt = pcnt_q - 1'b1;
            end else begin
                evnt_nxt = 1'b0;
            end
        end else begin
            pcnt_nxt = '0;
            if (tick_q) begin
                evnt_nxt = 1'b1;
                if (bus.evnt_ack) begin
                    ovr_nxt = 1'b0;
                end else if (evnt_q) begin
                    ovr_nxt = 1'b1;
                end
            end else if (bus.evnt_ack) begin
                evnt_nxt = 1'b0;
                ovr_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            evnt_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            pcnt_q <= pcnt_nxt;
            evnt_q <= evnt_nxt;
            ovr_q  <= ovr_nxt;
        end
    end

    assign bus.tick         = tick_q;
    assign bus.evnt         = evnt_q;
    assign bus.timer_status = status_q;
    assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_vm_event_timer.sv
// tb_vm_event_timer: directed scoreboard bench for vm_event_timer.
// Outputs packed as {tick, evnt, timer_status, overrun}.
module tb_vm_event_timer;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } snap_t;

    logic clk_p = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_run = 0;
    int   n_fail = 0;

    int    tq[$];
    snap_t sq[$];
    int    mon_t;
    snap_t mon_s;

    vm_event_timer_if vif();

    vm_event_timer #(
        .DIV_A(10),
        .DIV_B(8),
        .CNT_W(21),
        .PULSE_W(2),
        .DEB_DEPTH(2),
        .TIMER_INIT(1'b1)
    ) dut (
        .clk_p(clk_p),
        .rst_n(rst_n),
        .bus(vif)
    );

    always #5 clk_p = ~clk_p;

    always @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [3:0] outs();
        return {vif.tick, vif.evnt, vif.timer_status, vif.overrun};
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_empty(string name);
        n_run++;
        if (tq.size() != 0 || sq.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d ticks %0d snaps pending expected 0 0",
                     name, tq.size(), sq.size());
        end
    endtask

    task automatic exp_s(int c, logic [3:0] v);
        snap_t s;
        s.cyc = c;
        s.val = v;
        sq.push_back(s);
    endtask

    task automatic wait_cyc(int n);
        while (cyc != n) @(negedge clk_p);
    endtask

    task automatic ack_at(int n);
        wait_cyc(n);
        vif.evnt_ack = 1'b1;
        wait_cyc(n + 1);
        vif.evnt_ack = 1'b0;
    endtask

    // Monitor: every tick pops an expected tick cycle; snapshots are
    // compared when the run reaches their cycle.
    always @(negedge clk_p) begin
        if (rst_n === 1'b1) begin
            if (vif.tick === 1'b1) begin
                n_run++;
                if (tq.size() == 0) begin
                    n_fail++;
                    $display("FAIL tick: got tick at %0d expected none", cyc);
                end else begin
                    mon_t = tq.pop_front();
                    if (mon_t != cyc) begin
                        n_fail++;
                        $display("FAIL tick: got cycle %0d expected %0d", cyc, mon_t);
                    end
                end
            end
            while (sq.size() != 0 && sq[0].cyc < cyc) begin
                mon_s = sq.pop_front();
                n_run++;
                n_fail++;
                $display("FAIL snap@%0d: got no sample expected %b", mon_s.cyc, mon_s.val);
            end
            if (sq.size() != 0 && sq[0].cyc == cyc) begin
                mon_s = sq.pop_front();
                chk($sformatf("snap@%0d", cyc), outs(), mon_s.val);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vif.freq_sel     = 1'b0;
        vif.mode         = 1'b0;
        vif.evnt_ack     = 1'b0;
        vif.timer_button = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk_p);
        chk("reset", outs(), 4'b0010);

        // divider, divisor switch, pulse mode
        tq.push_back(9);
        tq.push_back(19);
        tq.push_back(27);
        for (int c = 35; c <= 179; c += 8) tq.push_back(c);
        exp_s(5,   4'b0010);
        exp_s(9,   4'b1010);
        exp_s(10,  4'b0110);
        exp_s(11,  4'b0110);
        exp_s(12,  4'b0010);
        exp_s(19,  4'b1010);
        exp_s(20,  4'b0110);
        exp_s(21,  4'b0110);
        exp_s(22,  4'b0010);
        exp_s(27,  4'b1010);
        exp_s(28,  4'b0110);
        exp_s(29,  4'b0110);
        exp_s(30,  4'b0010);
        exp_s(35,  4'b1010);
        exp_s(36,  4'b0110);
        exp_s(37,  4'b0110);
        exp_s(38,  4'b0010);
        // latched mode, overrun and ack
        exp_s(43,  4'b1010);
        exp_s(44,  4'b0110);
        exp_s(50,  4'b0110);
        exp_s(51,  4'b1110);
        exp_s(52,  4'b0111);
        exp_s(55,  4'b0010);
        exp_s(59,  4'b1010);
        exp_s(60,  4'b0110);
        exp_s(68,  4'b0111);
        exp_s(75,  4'b1111);
        exp_s(76,  4'b0110);
        exp_s(79,  4'b0010);
        exp_s(81,  4'b0010);
        // button toggle off, hold, toggle on
        exp_s(83,  4'b1010);
        exp_s(84,  4'b0110);
        exp_s(87,  4'b0010);
        exp_s(91,  4'b1010);
        exp_s(92,  4'b0110);
        exp_s(99,  4'b1110);
        exp_s(100, 4'b0101);
        exp_s(101, 4'b0001);
        exp_s(107, 4'b1001);
        exp_s(108, 4'b0001);
        exp_s(139, 4'b1001);
        exp_s(140, 4'b0011);
        exp_s(142, 4'b0010);
        exp_s(148, 4'b0110);
        // glitch: no toggle
        exp_s(156, 4'b0111);
        exp_s(164, 4'b0111);
        exp_s(172, 4'b0111);
        exp_s(180, 4'b0111);
        exp_s(181, 4'b0111);

        @(negedge clk_p);
        rst_n = 1'b1;

        wait_cyc(14);
        vif.freq_sel = 1'b1;
        wait_cyc(40);
        vif.mode = 1'b1;
        ack_at(54);
        ack_at(75);
        ack_at(78);
        ack_at(80);
        wait_cyc(84);
        vif.timer_button = 1'b1;
        ack_at(86);
        wait_cyc(108);
        vif.timer_button = 1'b0;
        wait_cyc(124);
        vif.timer_button = 1'b1;
        ack_at(141);
        vif.timer_button = 1'b0;
        wait_cyc(158);
        vif.timer_button = 1'b1;
        wait_cyc(166);
        vif.timer_button = 1'b0;

        // asynchronous reset mid-count with a request pending
        wait_cyc(181);
        #2 rst_n = 1'b0;
        #1 chk("async reset mid-count", outs(), 4'b0010);
        chk_empty("queues before reset 1");
        vif.mode     = 1'b0;
        vif.freq_sel = 1'b0;
        tq.push_back(9);
        exp_s(10, 4'b0110);
        @(negedge clk_p);
        @(negedge clk_p);
        rst_n = 1'b1;

        // asynchronous reset mid-pulse
        wait_cyc(10);
        #2 rst_n = 1'b0;
        #1 chk("async reset mid-pulse", outs(), 4'b0010);
        chk_empty("queues before reset 2");
        tq.push_back(9);
        tq.push_back(19);
        exp_s(5,  4'b0010);
        exp_s(9,  4'b1010);
        exp_s(10, 4'b0110);
        exp_s(11, 4'b0110);
        exp_s(12, 4'b0010);
        exp_s(19, 4'b1010);
        exp_s(20, 4'b0110);
        exp_s(21, 4'b0110);
        exp_s(22, 4'b0010);
        @(negedge clk_p);
        rst_n = 1'b1;
        wait_cyc(25);
        chk_empty("queues at end");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
